// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the RV64M multiply/divide unit: FSM state codes,
// M-extension funct3 encodings and small decode helpers.
package exe_muldiv_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  function automatic logic md_div_signed(input logic [2:0] f3);
    return (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

endpackage

// File: rtl/exe_muldiv_div.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per cycle,
// XLEN iterations or XLEN/2 for word operations.
module exe_muldiv_div
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            last,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   r_shift_s;
  logic [XLEN:0]   diff_s;

  // Load or iterate: word dividends are parked in the upper half so their MSB shifts out first.
  always_comb begin
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    r_shift_s = {rem_q, quot_q[XLEN-1]};
    diff_s    = r_shift_s - {1'b0, dvs_q};
    if (start) begin
      dvs_d = divisor;
      rem_d = {XLEN{1'b0}};
      if (word) begin
        cnt_d  = CNT_HALF;
        quot_d = {dividend[HALF-1:0], {HALF{1'b0}}};
      end else begin
        cnt_d  = CNT_FULL;
        quot_d = dividend;
      end
    end else if (busy) begin
      cnt_d = cnt_q - CNT_ONE;
      if (!diff_s[XLEN]) begin
        rem_d  = diff_s[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = r_shift_s[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= CNT_ZERO;
      quot_q <= {XLEN{1'b0}};
      rem_q  <= {XLEN{1'b0}};
      dvs_q  <= {XLEN{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy = (cnt_q != CNT_ZERO);
  assign last = (cnt_q == CNT_ONE);
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/exe_muldiv.sv
// RV64M multiply/divide unit of the execute stage: FSM, operand conditioning,
// single-cycle multiplier, divider sign fix-up and result register.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_flush,
  input  logic            md_start,
  input  logic [2:0]      md_funct3,
  input  logic            md_word,
  input  logic [XLEN-1:0] md_a,
  input  logic [XLEN-1:0] md_b,
  output logic            exe_ready,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int HALF = XLEN / 2;

  logic [2:0]        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sgn_in_s, sdiv_in_s, div0_s, ovf_s, div_start_s;
  logic [XLEN-1:0]   a_in_s, b_in_s, min_in_s, special_s, a_mag_s, b_mag_s;
  logic              mul_sa_s, mul_sb_s, a_neg_s, b_neg_s;
  logic [2*XLEN-1:0] mul_a_s, mul_b_s, prod_s;
  logic [XLEN-1:0]   mul_res_s, quot_s, rem_s, fix_res_s;
  logic              div_busy_s, div_last_s;
  logic [XLEN-1:0]   div_quot_s, div_rem_s;

  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] x);
    if (w) begin
      return {{HALF{x[HALF-1]}}, x[HALF-1:0]};
    end else begin
      return x;
    end
  endfunction

  // Incoming operands: W forms truncate then extend; detect the two early-exit divide cases.
  always_comb begin
    sgn_in_s  = ~md_funct3[0];
    sdiv_in_s = md_div_signed(md_funct3);
    if (md_word) begin
      a_in_s   = {{HALF{sgn_in_s & md_a[HALF-1]}}, md_a[HALF-1:0]};
      b_in_s   = {{HALF{sgn_in_s & md_b[HALF-1]}}, md_b[HALF-1:0]};
      min_in_s = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      a_in_s   = md_a;
      b_in_s   = md_b;
      min_in_s = {1'b1, {(XLEN-1){1'b0}}};
    end
    div0_s = md_funct3[2] & (b_in_s == {XLEN{1'b0}});
    ovf_s  = sdiv_in_s & (a_in_s == min_in_s) & (b_in_s == {XLEN{1'b1}});
    if (div0_s) begin
      special_s = md_funct3[1] ? a_in_s : {XLEN{1'b1}};
    end else begin
      special_s = md_funct3[1] ? {XLEN{1'b0}} : a_in_s;
    end
    a_mag_s = (sdiv_in_s & a_in_s[XLEN-1]) ? -a_in_s : a_in_s;
    b_mag_s = (sdiv_in_s & b_in_s[XLEN-1]) ? -b_in_s : b_in_s;
  end

  // Multiplier and divider sign fix-up, both working from the latched operands.
  always_comb begin
    mul_sa_s  = (funct3_q == MD_MULH) | (funct3_q == MD_MULHSU);
    mul_sb_s  = (funct3_q == MD_MULH);
    mul_a_s   = {{XLEN{mul_sa_s & a_q[XLEN-1]}}, a_q};
    mul_b_s   = {{XLEN{mul_sb_s & b_q[XLEN-1]}}, b_q};
    prod_s    = mul_a_s * mul_b_s;
    mul_res_s = (funct3_q == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    a_neg_s   = md_div_signed(funct3_q) & a_q[XLEN-1];
    b_neg_s   = md_div_signed(funct3_q) & b_q[XLEN-1];
    quot_s    = (a_neg_s ^ b_neg_s) ? -div_quot_s : div_quot_s;
    rem_s     = a_neg_s ? -div_rem_s : div_rem_s;
    fix_res_s = funct3_q[1] ? rem_s : quot_s;
  end

  // Control FSM; a flush overrides everything and latches nothing.
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    word_d      = word_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    div_start_s = 1'b0;
    if (md_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_start) begin
            funct3_d = md_funct3;
            word_d   = md_word;
            a_d      = a_in_s;
            b_d      = b_in_s;
            if (div0_s | ovf_s) begin
              result_d = wfix(md_word, special_s);
              state_d  = ST_DONE;
            end else if (!md_funct3[2]) begin
              state_d = ST_MUL;
            end else begin
              div_start_s = 1'b1;
              state_d     = ST_DIV;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          result_d = wfix(word_q, mul_res_s);
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          if (div_last_s || !div_busy_s) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_DIV;
          end
        end
        ST_FIX: begin
          result_d = wfix(word_q, fix_res_s);
          state_d  = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Unit state and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      funct3_q <= 3'b000;
      word_q   <= 1'b0;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      word_q   <= word_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  exe_muldiv_div #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .word     (md_word),
    .dividend (a_mag_s),
    .divisor  (b_mag_s),
    .busy     (div_busy_s),
    .last     (div_last_s),
    .quot     (div_quot_s),
    .rem      (div_rem_s)
  );

  assign exe_ready = ((state_q == ST_IDLE) & ~md_start) | (state_q == ST_DONE) | md_flush;
  assign md_done   = (state_q == ST_DONE) & ~md_flush;
  assign md_result = result_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: arithmetic reference model with latency, per-cycle
// compare of md_done / exe_ready / md_result, plus literal pins on the model.
module tb_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        md_flush = 1'b0;
  logic        md_start = 1'b0;
  logic [2:0]  md_funct3 = 3'b000;
  logic        md_word = 1'b0;
  logic [63:0] md_a = 64'd0;
  logic [63:0] md_b = 64'd0;
  logic        exe_ready;
  logic        md_done;
  logic [63:0] md_result;

  exe_muldiv #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .md_flush  (md_flush),
    .md_start  (md_start),
    .md_funct3 (md_funct3),
    .md_word   (md_word),
    .md_a      (md_a),
    .md_b      (md_b),
    .exe_ready (exe_ready),
    .md_done   (md_done),
    .md_result (md_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  bit          exp_busy = 1'b0;
  int          exp_start = 0;
  int          exp_due = 0;
  int          exp_lat = 0;
  logic [63:0] exp_res = 64'd0;
  logic [63:0] exp_hold = 64'd0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_res(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0]    p;
    int              sa, sb;
    int unsigned     ua, ub;
    longint          la, lb;
    longint unsigned qa, qb;
    logic [31:0]     r32;
    logic [63:0]     r;
    r = 64'd0;
    if (w) begin
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      case (f3)
        3'b100: begin
          if (ub == 0) r32 = 32'hFFFF_FFFF;
          else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = ua;
          else r32 = sa / sb;
        end
        3'b101: begin
          if (ub == 0) r32 = 32'hFFFF_FFFF;
          else r32 = ua / ub;
        end
        3'b110: begin
          if (ub == 0) r32 = ua;
          else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r32 = 32'd0;
          else r32 = sa % sb;
        end
        3'b111: begin
          if (ub == 0) r32 = ua;
          else r32 = ua % ub;
        end
        default: r32 = sa * sb;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      la = a; lb = b; qa = a; qb = b;
      case (f3)
        3'b000: r = la * lb;
        3'b001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'b010: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
        3'b011: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
        3'b100: begin
          if (b == 64'd0) r = ONES;
          else if (a == MIN64 && b == ONES) r = a;
          else r = la / lb;
        end
        3'b101: begin
          if (b == 64'd0) r = ONES;
          else r = qa / qb;
        end
        3'b110: begin
          if (b == 64'd0) r = a;
          else if (a == MIN64 && b == ONES) r = 64'd0;
          else r = la % lb;
        end
        default: begin
          if (b == 64'd0) r = a;
          else r = qa % qb;
        end
      endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf, sgn;
    if (!f3[2]) return 2;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    if (w) begin
      zero = (b[31:0] == 32'd0);
      ovf  = sgn && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    end else begin
      zero = (b == 64'd0);
      ovf  = sgn && (a == MIN64) && (b == ONES);
    end
    if (zero || ovf) return 1;
    return w ? 34 : 66;
  endfunction

  // Drive a new op in the current cycle and arm the model.
  task automatic start_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] lit, input int lat_lit);
    md_funct3 = f3; md_word = w; md_a = a; md_b = b; md_start = 1'b1;
    exp_res = model_res(f3, w, a, b);
    exp_lat = model_lat(f3, w, a, b);
    chk("model_result", exp_res, lit);
    chk("model_latency", 64'(exp_lat), 64'(lat_lit));
    exp_start = cyc;
    exp_due   = cyc + exp_lat;
    exp_busy  = 1'b1;
  endtask

  // Run an op to completion, leaving md_start high for a possible back-to-back op.
  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] lit, input int lat_lit);
    start_op(f3, w, a, b, lit, lat_lit);
    repeat (exp_lat + 1) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    md_start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare of all outputs against the model.
  initial begin
    bit exp_done, exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_busy = 1'b0;
        exp_hold = 64'd0;
        chk("reset_done", 64'(md_done), 64'd0);
        chk("reset_ready", 64'(exe_ready), 64'(!md_start));
        chk("reset_result", md_result, 64'd0);
      end else begin
        exp_done = exp_busy && (cyc == exp_due) && !md_flush;
        if (md_flush) exp_rdy = 1'b1;
        else if (exp_busy && cyc != exp_start) exp_rdy = (cyc == exp_due);
        else exp_rdy = !md_start;
        if (exp_done) exp_hold = exp_res;
        chk("md_done", 64'(md_done), 64'(exp_done));
        chk("exe_ready", 64'(exe_ready), 64'(exp_rdy));
        chk("md_result", md_result, exp_hold);
        if (md_flush || (exp_busy && cyc == exp_due)) exp_busy = 1'b0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    do_op(3'b000, 1'b0, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1, 2);
    idle(1);
    do_op(3'b011, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    do_op(3'b010, 1'b0, ONES, 64'd2, ONES, 2);
    do_op(3'b001, 1'b0, ONES, ONES, 64'd0, 2);
    do_op(3'b000, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    idle(1);

    do_op(3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    do_op(3'b110, 1'b0, -64'sd7, 64'd2, ONES, 66);
    do_op(3'b101, 1'b1, 64'h1_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 34);
    do_op(3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    do_op(3'b101, 1'b0, ONES, 64'd3, 64'h5555_5555_5555_5555, 66);
    do_op(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    idle(1);

    do_op(3'b101, 1'b0, 64'd123, 64'd0, ONES, 1);
    do_op(3'b100, 1'b0, MIN64, ONES, MIN64, 1);
    do_op(3'b110, 1'b0, MIN64, ONES, 64'd0, 1);
    do_op(3'b110, 1'b1, 64'd5, 64'h7777_0000_0000_0000, 64'd5, 1);
    do_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1);
    idle(1);

    // start and flush together: nothing may be captured
    md_funct3 = 3'b000; md_word = 1'b0; md_a = 64'd9; md_b = 64'd9;
    md_start = 1'b1; md_flush = 1'b1;
    @(posedge clk); #1;
    md_flush = 1'b0;
    idle(2);

    // flush at cycle 10 of a divide, then a multiply right behind it
    start_op(3'b100, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66);
    repeat (10) @(posedge clk);
    #1;
    md_flush = 1'b1; md_start = 1'b0;
    @(posedge clk); #1;
    md_flush = 1'b0;
    do_op(3'b000, 1'b0, 64'd6, 64'd7, 64'd42, 2);
    idle(1);

    // asynchronous reset in the middle of a divide
    start_op(3'b100, 1'b0, 64'd1000, 64'd3, 64'd333, 66);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0; md_start = 1'b0;
    exp_busy = 1'b0; exp_hold = 64'd0;
    #1;
    chk("async_ready", 64'(exe_ready), 64'd1);
    chk("async_done", 64'(md_done), 64'd0);
    chk("async_result", md_result, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // back-to-back with start held
    do_op(3'b100, 1'b0, 64'd50, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF9, 66);
    do_op(3'b000, 1'b0, -64'sd4, -64'sd4, 64'd16, 2);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
